// File: rtl/fp_mul_ctrl.sv
// fp_mul_ctrl: issue/writeback controller around a 2-stage binary32 multiplier.
//   Accepts one multiply at a time on a valid/ready request port and holds the
//   operands, rounding mode and tag stable while fp_mul works through both
//   stages. The result and exception flags are captured into a single-entry
//   response register with valid/ready. It also keeps a sticky CSR flag set
//   (fflags).
// Ports:
//   clk, rst                  clock, async active-high reset
//   in_valid/in_ready         request handshake
//   in_a, in_b, in_rm, in_tag operands, rounding mode (0 RNE, 1 RZ, 2 RDN, 3 RUP, 4 RMM), tag
//   flush                     synchronous abort of the in-flight op
//   res_valid/res_ready       response handshake
//   res_data, res_flags       product and {NV,DZ,OF,UF,NX} of this op
//   res_tag                   tag of this op
//   fflags, fflags_clr        sticky OR of loaded res_flags, and its clear
//
// fp_mul: binary32 multiplier (W must be 32) with two register stages.
//   Stage 1 registers the significand product. Stage 2 reads in1/in2/round_m
//   combinationally, so the caller holds them stable for the whole op.
// Ports:
//   clk, rst_n                clock, async active-low reset
//   act                       enables both register stages
//   in1, in2, round_m         operands and rounding mode
//   out, ov, un, inv, inexact registered result and IEEE exception flags

module fp_mul #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         act,
  input  logic [W-1:0] in1,
  input  logic [W-1:0] in2,
  input  logic [2:0]   round_m,
  output logic [W-1:0] out,
  output logic         ov,
  output logic         un,
  output logic         inv,
  output logic         inexact
);

  localparam logic [2:0]  RM_RZ  = 3'd1;
  localparam logic [2:0]  RM_RDN = 3'd2;
  localparam logic [2:0]  RM_RUP = 3'd3;
  localparam logic [2:0]  RM_RMM = 3'd4;
  localparam logic [31:0] NANQ   = 32'h7FC0_0000;

  logic [7:0]         ea, eb, xa, xb;
  logic [22:0]        fa, fb;
  logic [23:0]        sig_a, sig_b;
  logic [47:0]        prod_q, norm;
  logic [5:0]         lz, sh;
  logic signed [10:0] e_r;
  logic [94:0]        den;
  logic               tiny, huge, sign;
  logic               a_nan, b_nan, a_snan, b_snan, a_inf, b_inf, a_zero, b_zero;

  logic [7:0]  exp_f;
  logic [22:0] mant;
  logic        g, s, inc, to_inf;
  logic [30:0] rounded;

  logic [W-1:0] out_nxt;
  logic         ov_nxt, un_nxt, inv_nxt, nx_nxt;

  assign ea    = in1[30:23];
  assign eb    = in2[30:23];
  assign fa    = in1[22:0];
  assign fb    = in2[22:0];
  assign sig_a = {|ea, fa};
  assign sig_b = {|eb, fb};
  // Subnormals share the exponent of the smallest normal.
  assign xa    = (ea == 8'd0) ? 8'd1 : ea;
  assign xb    = (eb == 8'd0) ? 8'd1 : eb;
  assign sign  = in1[31] ^ in2[31];

  assign a_nan  = (&ea) && (|fa);
  assign b_nan  = (&eb) && (|fb);
  assign a_snan = a_nan && !fa[22];
  assign b_snan = b_nan && !fb[22];
  assign a_inf  = (&ea) && !(|fa);
  assign b_inf  = (&eb) && !(|fb);
  assign a_zero = (in1[30:0] == 31'd0);
  assign b_zero = (in2[30:0] == 31'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prod_q <= '0;
    else if (act) prod_q <= 48'(sig_a) * 48'(sig_b);
  end

  always_comb begin
    lz = 6'd0;
    for (int i = 0; i < 48; i++)
      if (prod_q[i]) lz = 6'(47 - i);
  end

  // norm has its leading one at bit 47; e_r is the biased exponent of that value.
  assign norm = prod_q << lz;
  assign e_r  = 11'(xa) + 11'(xb) - 11'd126 - 11'(lz);
  // Tininess is detected before rounding.
  assign tiny = e_r < 11'sd1;
  assign huge = e_r > 11'sd254;
  assign sh   = (e_r < -11'sd62) ? 6'd63 : 6'(11'sd1 - e_r);
  assign den  = {norm, 47'd0} >> sh;

  always_comb begin
    if (tiny) begin
      // A surviving hidden bit would carry into exponent field 1.
      exp_f = {7'd0, den[94]};
      mant  = den[93:71];
      g     = den[70];
      s     = |den[69:0];
    end else begin
      exp_f = e_r[7:0];
      mant  = norm[46:24];
      g     = norm[23];
      s     = |norm[22:0];
    end
  end

  always_comb begin
    case (round_m)
      RM_RZ:   begin inc = 1'b0;               to_inf = 1'b0;  end
      RM_RDN:  begin inc = sign & (g | s);     to_inf = sign;  end
      RM_RUP:  begin inc = !sign & (g | s);    to_inf = !sign; end
      RM_RMM:  begin inc = g;                  to_inf = 1'b1;  end
      default: begin inc = g & (s | mant[0]); to_inf = 1'b1;  end
    endcase
  end

  // Mantissa carry ripples into the exponent field; 0xFF there means overflow.
  assign rounded = {exp_f, mant} + 31'(inc);

  always_comb begin
    out_nxt = '0;
    ov_nxt  = 1'b0;
    un_nxt  = 1'b0;
    inv_nxt = 1'b0;
    nx_nxt  = 1'b0;
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
      out_nxt = NANQ;
      inv_nxt = a_snan || b_snan || (a_inf && b_zero) || (b_inf && a_zero);
    end else if (a_inf || b_inf) begin
      out_nxt = {sign, 8'hFF, 23'd0};
    end else if (a_zero || b_zero) begin
      out_nxt = {sign, 31'd0};
    end else if (huge || (rounded[30:23] == 8'hFF)) begin
      out_nxt = to_inf ? {sign, 8'hFF, 23'd0} : {sign, 8'hFE, {23{1'b1}}};
      ov_nxt  = 1'b1;
      nx_nxt  = 1'b1;
    end else begin
      out_nxt = {sign, rounded};
      nx_nxt  = g | s;
      un_nxt  = tiny && (g | s);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out     <= '0;
      ov      <= 1'b0;
      un      <= 1'b0;
      inv     <= 1'b0;
      inexact <= 1'b0;
    end else if (act) begin
      out     <= out_nxt;
      ov      <= ov_nxt;
      un      <= un_nxt;
      inv     <= inv_nxt;
      inexact <= nx_nxt;
    end
  end

endmodule

// state | meaning
// IDLE  | no op in flight, request port open
// S1    | operands held, fp_mul stage-1 register loads at end of cycle
// S2    | operands held, fp_mul output registers load at end of cycle
// WB    | fp_mul outputs valid, waiting for a free response slot
module fp_mul_ctrl #(
  parameter int W    = 32,
  parameter int TAGW = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [W-1:0]    in_a,
  input  logic [W-1:0]    in_b,
  input  logic [2:0]      in_rm,
  input  logic [TAGW-1:0] in_tag,
  input  logic            flush,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [W-1:0]    res_data,
  output logic [4:0]      res_flags,
  output logic [TAGW-1:0] res_tag,
  output logic [4:0]      fflags,
  input  logic            fflags_clr
);

  typedef enum logic [1:0] {IDLE, S1, S2, WB} state_t;

  state_t          state, state_nxt;
  logic [W-1:0]    a_q, b_q;
  logic [2:0]      rm_q;
  logic [TAGW-1:0] tag_q;
  logic            act, slot_free, accept, load;
  logic [W-1:0]    mul_out;
  logic            mul_ov, mul_un, mul_inv, mul_nx;
  logic [4:0]      mul_flags;

  assign slot_free = !res_valid || res_ready;
  assign accept    = in_valid && in_ready && !flush;
  assign load      = (state == WB) && slot_free && !flush;
  assign mul_flags = {mul_inv, 1'b0, mul_ov, mul_un, mul_nx};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = S1;
      S1:   state_nxt = flush ? IDLE : S2;
      S2:   state_nxt = flush ? IDLE : WB;
      WB: begin
        if (flush)          state_nxt = IDLE;
        else if (slot_free) state_nxt = in_valid ? S1 : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state == IDLE) || ((state == WB) && slot_free);
    act      = (state != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q       <= '0;
      b_q       <= '0;
      rm_q      <= '0;
      tag_q     <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_flags <= '0;
      res_tag   <= '0;
      fflags    <= '0;
    end else begin
      if (accept) begin
        a_q   <= in_a;
        b_q   <= in_b;
        rm_q  <= in_rm;
        tag_q <= in_tag;
      end
      if (load) begin
        res_data  <= mul_out;
        res_flags <= mul_flags;
        res_tag   <= tag_q;
      end
      // A reload on the same edge as a consume keeps the entry valid.
      if (load)           res_valid <= 1'b1;
      else if (res_ready) res_valid <= 1'b0;
      fflags <= (fflags_clr ? 5'd0 : fflags) | (load ? mul_flags : 5'd0);
    end
  end

  fp_mul #(.W(W)) u_fp_mul (
    .clk     (clk),
    .rst_n   (~rst),
    .act     (act),
    .in1     (a_q),
    .in2     (b_q),
    .round_m (rm_q),
    .out     (mul_out),
    .ov      (mul_ov),
    .un      (mul_un),
    .inv     (mul_inv),
    .inexact (mul_nx)
  );

endmodule

// File: tb/tb_fp_mul_ctrl.sv
// Directed bench for fp_mul_ctrl: hand-computed products, flags, handshake
// timing, backpressure, sticky flags, reset and flush.
module tb_fp_mul_ctrl;

  localparam logic [2:0] RNE = 3'd0;
  localparam logic [2:0] RZ  = 3'd1;
  localparam logic [2:0] RDN = 3'd2;
  localparam logic [2:0] RUP = 3'd3;
  localparam logic [2:0] RMM = 3'd4;

  logic        clk, rst;
  logic        in_valid, in_ready;
  logic [31:0] in_a, in_b;
  logic [2:0]  in_rm;
  logic [3:0]  in_tag;
  logic        flush;
  logic        res_valid, res_ready;
  logic [31:0] res_data;
  logic [4:0]  res_flags;
  logic [3:0]  res_tag;
  logic [4:0]  fflags;
  logic        fflags_clr;

  int n_tests = 0;
  int n_fail  = 0;
  int lat;
  int seen;
  logic [4:0] exp_ff;

  fp_mul_ctrl #(.W(32), .TAGW(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_rm      (in_rm),
    .in_tag     (in_tag),
    .flush      (flush),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_flags  (res_flags),
    .res_tag    (res_tag),
    .fflags     (fflags),
    .fflags_clr (fflags_clr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [2:0] rm,
                       input logic [3:0] tag);
    in_a     = a;
    in_b     = b;
    in_rm    = rm;
    in_tag   = tag;
    in_valid = 1'b1;
  endtask

  // Issue from IDLE and count edges from the accept edge until res_valid.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] rm,
                        input logic [3:0] tag, output int l);
    check("issue_ready", {31'd0, in_ready}, 32'd1);
    drive(a, b, rm, tag);
    step();
    in_valid = 1'b0;
    l = 0;
    while (!res_valid && l < 8) begin
      step();
      l++;
    end
  endtask

  task automatic pop();
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
  endtask

  task automatic do_vec(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] rm, input logic [31:0] r, input logic [4:0] f);
    run_op(a, b, rm, 4'hA, lat);
    exp_ff = exp_ff | f;
    check({name, "_lat"}, lat, 32'd3);
    check({name, "_data"}, res_data, r);
    check({name, "_flags"}, {27'd0, res_flags}, {27'd0, f});
    check({name, "_fflags"}, {27'd0, fflags}, {27'd0, exp_ff});
    pop();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_rm = '0; in_tag = '0;
    flush = 1'b0; res_ready = 1'b0; fflags_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    step();
    check("rst_in_ready",  {31'd0, in_ready},  32'd1);
    check("rst_res_valid", {31'd0, res_valid}, 32'd0);
    check("rst_res_data",  res_data,           32'd0);
    check("rst_res_flags", {27'd0, res_flags}, 32'd0);
    check("rst_res_tag",   {28'd0, res_tag},   32'd0);
    check("rst_fflags",    {27'd0, fflags},    32'd0);

    // 1.5 * 2.0 = 3.0
    run_op(32'h3FC0_0000, 32'h4000_0000, RNE, 4'd5, lat);
    check("t1_lat",   lat,                32'd3);
    check("t1_data",  res_data,           32'h4040_0000);
    check("t1_flags", {27'd0, res_flags}, 32'd0);
    check("t1_tag",   {28'd0, res_tag},   32'd5);

    // Backpressure: second op (3.0 * -2.5) parks in WB behind the held result.
    drive(32'h4040_0000, 32'hC020_0000, RNE, 4'd7);
    step();
    in_valid = 1'b0;
    repeat (3) step();
    check("t2_in_ready_busy", {31'd0, in_ready},  32'd0);
    check("t2_hold_valid",    {31'd0, res_valid}, 32'd1);
    check("t2_hold_data",     res_data,           32'h4040_0000);
    check("t2_hold_tag",      {28'd0, res_tag},   32'd5);
    repeat (2) step();
    check("t2_hold_data2",    res_data,           32'h4040_0000);
    res_ready = 1'b1;
    step();
    check("t2_second_valid", {31'd0, res_valid}, 32'd1);
    check("t2_second_data",  res_data,           32'hC0F0_0000);
    check("t2_second_tag",   {28'd0, res_tag},   32'd7);
    check("t2_second_flags", {27'd0, res_flags}, 32'd0);
    step();
    check("t2_drained", {31'd0, res_valid}, 32'd0);
    res_ready = 1'b0;

    // inf * 0 -> invalid, canonical qNaN
    run_op(32'h7F80_0000, 32'h0000_0000, RNE, 4'd1, lat);
    check("t3_data",   res_data,           32'h7FC0_0000);
    check("t3_flags",  {27'd0, res_flags}, 32'h10);
    check("t3_fflags", {27'd0, fflags},    32'h10);
    pop();

    // (1+2^-23)^2, RZ then RNE with a clear on the load edge
    run_op(32'h3F80_0001, 32'h3F80_0001, RZ, 4'd2, lat);
    check("t4_rz_data",   res_data,           32'h3F80_0002);
    check("t4_rz_flags",  {27'd0, res_flags}, 32'h01);
    check("t4_rz_fflags", {27'd0, fflags},    32'h11);
    pop();
    drive(32'h3F80_0001, 32'h3F80_0001, RNE, 4'd3);
    step();
    in_valid = 1'b0;
    step();
    step();
    fflags_clr = 1'b1;
    step();
    fflags_clr = 1'b0;
    check("t4_rne_valid",  {31'd0, res_valid}, 32'd1);
    check("t4_rne_data",   res_data,           32'h3F80_0002);
    check("t4_clr_vs_nx",  {27'd0, fflags},    32'h01);
    pop();
    fflags_clr = 1'b1;
    step();
    fflags_clr = 1'b0;
    check("t4_clr_alone", {27'd0, fflags}, 32'd0);

    exp_ff = 5'd0;
    do_vec("neg_mul",   32'h4040_0000, 32'hC020_0000, RNE, 32'hC0F0_0000, 5'b00000);
    do_vec("rup_nx",    32'h3F80_0001, 32'h3F80_0001, RUP, 32'h3F80_0003, 5'b00001);
    do_vec("ovf_rne",   32'h7F00_0000, 32'h7F00_0000, RNE, 32'h7F80_0000, 5'b00101);
    do_vec("ovf_rz",    32'h7F00_0000, 32'h7F00_0000, RZ,  32'h7F7F_FFFF, 5'b00101);
    do_vec("ovf_neg",   32'hFF00_0000, 32'h7F00_0000, RUP, 32'hFF7F_FFFF, 5'b00101);
    do_vec("sub_exact", 32'h0080_0000, 32'h3F00_0000, RNE, 32'h0040_0000, 5'b00000);
    do_vec("sub_tie",   32'h0080_0001, 32'h3F00_0000, RNE, 32'h0040_0000, 5'b00011);
    do_vec("sub_rmm",   32'h0080_0001, 32'h3F00_0000, RMM, 32'h0040_0001, 5'b00011);
    do_vec("sub_rdn",   32'h0080_0001, 32'h3F00_0000, RDN, 32'h0040_0000, 5'b00011);
    do_vec("snan",      32'h7FA0_0000, 32'h3F80_0000, RNE, 32'h7FC0_0000, 5'b10000);

    // Reset while the op sits in S2
    drive(32'h3FC0_0000, 32'h4000_0000, RNE, 4'd6);
    step();
    in_valid = 1'b0;
    step();
    rst = 1'b1;
    #1;
    check("t5_in_ready",  {31'd0, in_ready},  32'd1);
    check("t5_res_valid", {31'd0, res_valid}, 32'd0);
    check("t5_res_data",  res_data,           32'd0);
    check("t5_res_flags", {27'd0, res_flags}, 32'd0);
    check("t5_res_tag",   {28'd0, res_tag},   32'd0);
    check("t5_fflags",    {27'd0, fflags},    32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    seen = 0;
    repeat (6) begin
      step();
      if (res_valid) seen++;
    end
    check("t5_no_resp", seen, 32'd0);

    // Flush in S1, then a fresh op
    drive(32'h4040_0000, 32'h4040_0000, RNE, 4'd4);
    step();
    in_valid = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("t6_idle_ready", {31'd0, in_ready}, 32'd1);
    seen = 0;
    repeat (5) begin
      step();
      if (res_valid) seen++;
    end
    check("t6_no_resp", seen, 32'd0);
    run_op(32'h3FC0_0000, 32'h4000_0000, RNE, 4'd9, lat);
    check("t6_lat",  lat,              32'd3);
    check("t6_data", res_data,         32'h4040_0000);
    check("t6_tag",  {28'd0, res_tag}, 32'd9);
    pop();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
